// File: rtl/mem_tile_obi_initializer.sv
// mem_tile_obi_initializer
//   OBI manager that walks a contiguous window of the memory tile. It writes a
//   per-word pattern to every word and, optionally, reads each word back and
//   compares it against the same pattern. It is used for boot-time
//   zeroing/preload and for built-in memory checks.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   start_i                  start a run (accepted only in IDLE or DONE)
//   check_i, base_addr_i,
//   pattern_i                run configuration, captured together with start_i
//   obi_req_o/obi_gnt_i      OBI A-channel handshake
//   obi_addr_o, obi_we_o,
//   obi_be_o, obi_wdata_o    OBI A-channel payload (registered)
//   obi_rvalid_i/obi_rdata_i OBI R-channel, responses arrive in order
//   busy_o, done_o           run status
//   error_o, err_addr_o,
//   err_count_o              compare result of the current/last run
module mem_tile_obi_initializer #(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned NumWords       = 4096,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     check_i,
  input  logic [AddrWidth-1:0]     base_addr_i,
  input  logic [31:0]              pattern_i,
  output logic                     obi_req_o,
  input  logic                     obi_gnt_i,
  output logic [AddrWidth-1:0]     obi_addr_o,
  output logic                     obi_we_o,
  output logic [DataWidth/8-1:0]   obi_be_o,
  output logic [DataWidth-1:0]     obi_wdata_o,
  input  logic                     obi_rvalid_i,
  input  logic [DataWidth-1:0]     obi_rdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [AddrWidth-1:0]     err_addr_o,
  output logic [15:0]              err_count_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned Reps     = DataWidth / 32;
  localparam int unsigned IdxWidth = $clog2(NumWords + 1);
  localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumWords - 1);
  localparam logic [OutWidth-1:0] MaxOut  = OutWidth'(MaxOutstanding);
  localparam logic [IdxWidth-1:0] IdxZero = {IdxWidth{1'b0}};
  localparam logic [IdxWidth-1:0] IdxOne  = IdxWidth'(1'b1);
  localparam logic [OutWidth-1:0] OutZero = {OutWidth{1'b0}};
  localparam logic [OutWidth-1:0] OutOne  = OutWidth'(1'b1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WDRAIN = 3'd2,
    READ   = 3'd3,
    RDRAIN = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Pattern word for index idx, replicated across the data bus.
  function automatic logic [DataWidth-1:0] word_data(input logic [31:0]         seed,
                                                     input logic [IdxWidth-1:0] idx);
    logic [31:0] w;
    w = seed ^ 32'(idx);
    return {Reps{w}};
  endfunction

  // Byte address of word idx inside the window.
  function automatic logic [AddrWidth-1:0] word_addr(input logic [AddrWidth-1:0] base,
                                                     input logic [IdxWidth-1:0]  idx);
    return base + AddrWidth'(idx) * AddrWidth'(BeWidth);
  endfunction

  state_e                state_r;
  logic [IdxWidth-1:0]   idx_r;
  logic [IdxWidth-1:0]   cmp_idx_r;
  logic [OutWidth-1:0]   out_r;
  logic [AddrWidth-1:0]  base_r;
  logic [31:0]           pattern_r;
  logic                  check_r;

  logic                  fire_s;
  logic                  rsp_s;
  logic                  cmp_s;
  logic                  mismatch_s;
  logic                  run_s;
  logic [OutWidth-1:0]   out_next_s;
  logic [IdxWidth-1:0]   idx_next_s;
  logic                  can_issue_s;
  logic                  drained_s;

  // Next-cycle view of the handshake counters; req/addr/data are registered
  // from these so a fresh request can go out in the cycle after a grant.
  always_comb begin
    fire_s      = obi_req_o & obi_gnt_i;
    run_s       = (state_r == WRITE) || (state_r == WDRAIN) ||
                  (state_r == READ)  || (state_r == RDRAIN);
    // Responses outside a run (e.g. stragglers after reset) are discarded.
    rsp_s       = obi_rvalid_i && run_s && (out_r != OutZero);
    cmp_s       = obi_rvalid_i && ((state_r == READ) || (state_r == RDRAIN));
    mismatch_s  = cmp_s && (obi_rdata_i != word_data(pattern_r, cmp_idx_r));
    if (fire_s && !rsp_s) begin
      out_next_s = out_r + OutOne;
    end else if (!fire_s && rsp_s) begin
      out_next_s = out_r - OutOne;
    end else begin
      out_next_s = out_r;
    end
    if (fire_s) begin
      idx_next_s = idx_r + IdxOne;
    end else begin
      idx_next_s = idx_r;
    end
    can_issue_s = (out_next_s < MaxOut);
    drained_s   = (out_next_s == OutZero);
  end

  // Run sequencer, OBI request generation and compare bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      idx_r       <= IdxZero;
      cmp_idx_r   <= IdxZero;
      out_r       <= OutZero;
      base_r      <= {AddrWidth{1'b0}};
      pattern_r   <= 32'h0000_0000;
      check_r     <= 1'b0;
      obi_req_o   <= 1'b0;
      obi_addr_o  <= {AddrWidth{1'b0}};
      obi_we_o    <= 1'b0;
      obi_be_o    <= {BeWidth{1'b0}};
      obi_wdata_o <= {DataWidth{1'b0}};
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      err_addr_o  <= {AddrWidth{1'b0}};
      err_count_o <= 16'h0000;
    end else begin
      out_r <= out_next_s;
      if (cmp_s) begin
        cmp_idx_r <= cmp_idx_r + IdxOne;
      end
      if (mismatch_s) begin
        error_o <= 1'b1;
        if (err_count_o != 16'hFFFF) begin
          err_count_o <= err_count_o + 16'd1;
        end
        // Only the first mismatch of a run is reported by address.
        if (!error_o) begin
          err_addr_o <= word_addr(base_r, cmp_idx_r);
        end
      end
      case (state_r)
        IDLE, DONE: begin
          out_r <= OutZero;
          if (start_i) begin
            state_r     <= WRITE;
            base_r      <= base_addr_i;
            pattern_r   <= pattern_i;
            check_r     <= check_i;
            idx_r       <= IdxZero;
            cmp_idx_r   <= IdxZero;
            obi_req_o   <= 1'b1;
            obi_addr_o  <= base_addr_i;
            obi_we_o    <= 1'b1;
            obi_be_o    <= {BeWidth{1'b1}};
            obi_wdata_o <= word_data(pattern_i, IdxZero);
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            err_addr_o  <= {AddrWidth{1'b0}};
            err_count_o <= 16'h0000;
          end
        end
        WRITE, READ: begin
          idx_r <= idx_next_s;
          if (fire_s && (idx_r == LastIdx)) begin
            state_r   <= (state_r == WRITE) ? WDRAIN : RDRAIN;
            obi_req_o <= 1'b0;
          end else begin
            // While stalled idx is unchanged, so addr/data are reloaded with
            // the same values and out_next cannot grow: req stays up.
            obi_req_o   <= can_issue_s;
            obi_addr_o  <= word_addr(base_r, idx_next_s);
            obi_wdata_o <= (state_r == WRITE) ? word_data(pattern_r, idx_next_s)
                                              : {DataWidth{1'b0}};
          end
        end
        WDRAIN: begin
          if (drained_s && check_r) begin
            state_r     <= READ;
            idx_r       <= IdxZero;
            cmp_idx_r   <= IdxZero;
            obi_req_o   <= 1'b1;
            obi_addr_o  <= base_r;
            obi_we_o    <= 1'b0;
            obi_wdata_o <= {DataWidth{1'b0}};
          end else if (drained_s) begin
            state_r  <= DONE;
            obi_we_o <= 1'b0;
            obi_be_o <= {BeWidth{1'b0}};
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
          end
        end
        RDRAIN: begin
          if (drained_s) begin
            state_r  <= DONE;
            obi_be_o <= {BeWidth{1'b0}};
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          obi_req_o <= 1'b0;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_tile_obi_initializer.sv
// Directed bench for mem_tile_obi_initializer with a small in-order OBI SRAM
// model (configurable grant stalls, response delay and read corruption).
module tb_mem_tile_obi_initializer;

  localparam int AW = 48;
  localparam int DW = 512;
  localparam int NW = 8;
  localparam int MO = 2;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          check_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [31:0]   pattern_i = 32'h0;
  logic          obi_req_o;
  logic          obi_gnt_i = 1'b0;
  logic [AW-1:0] obi_addr_o;
  logic          obi_we_o;
  logic [BW-1:0] obi_be_o;
  logic [DW-1:0] obi_wdata_o;
  logic          obi_rvalid_i = 1'b0;
  logic [DW-1:0] obi_rdata_i = '0;
  logic          busy_o, done_o, error_o;
  logic [AW-1:0] err_addr_o;
  logic [15:0]   err_count_o;

  always #5 clk = ~clk;

  mem_tile_obi_initializer #(
    .AddrWidth(AW), .DataWidth(DW), .NumWords(NW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .check_i(check_i),
    .base_addr_i(base_addr_i), .pattern_i(pattern_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_addr_o(err_addr_o), .err_count_o(err_count_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [31:0] pat, input int i);
    logic [31:0] w;
    w = pat ^ i[31:0];
    return {(DW/32){w}};
  endfunction

  // ---------------- subordinate model ----------------
  typedef struct {
    logic we;
    int   idx;
    int   ready;
  } txn_t;

  txn_t          q[$];
  logic [DW-1:0] mem     [NW];
  logic [DW-1:0] corrupt [NW];
  int            cyc = 0, last_ready = 0;
  int            stall_en = 0, dly_mode = 0;
  int            n_writes = 0, n_reads = 0, exp_widx = 0, exp_ridx = 0;
  int            seq_err = 0, proto_err = 0;
  logic [AW-1:0] cur_base = '0;
  logic [31:0]   cur_pat = 32'h0;

  initial begin
    txn_t          t;
    int            d, r;
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic          prev_we;
    logic [DW-1:0] prev_wdata;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_we    = 1'b0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      // A stalled request must be held unchanged.
      if (prev_stall && rst_ni &&
          (!obi_req_o || obi_addr_o !== prev_addr || obi_we_o !== prev_we ||
           obi_wdata_o !== prev_wdata))
        proto_err++;
      if (q.size() > MO || (obi_req_o === 1'b1 && q.size() >= MO)) proto_err++;
      obi_rvalid_i = 1'b0;
      obi_rdata_i  = '0;
      if (q.size() > 0 && q[0].ready <= cyc) begin
        t = q.pop_front();
        obi_rvalid_i = 1'b1;
        if (!t.we) obi_rdata_i = mem[t.idx] ^ corrupt[t.idx];
      end
      obi_gnt_i = (stall_en != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (obi_req_o === 1'b1 && obi_gnt_i && rst_ni) begin
        d = (dly_mode == 0) ? 0 : (dly_mode == 1) ? int'($urandom_range(0, 3)) : 3;
        r = cyc + 1 + d;
        if (r <= last_ready) r = last_ready + 1;
        last_ready = r;
        if (obi_be_o !== {BW{1'b1}}) seq_err++;
        t.we = obi_we_o;
        t.ready = r;
        if (obi_we_o) begin
          if (obi_addr_o !== cur_base + AW'(exp_widx * BW) ||
              obi_wdata_o !== exp_data(cur_pat, exp_widx)) seq_err++;
          t.idx = exp_widx % NW;
          mem[t.idx] = obi_wdata_o;
          exp_widx++;
          n_writes++;
        end else begin
          if (obi_addr_o !== cur_base + AW'(exp_ridx * BW)) seq_err++;
          t.idx = exp_ridx % NW;
          exp_ridx++;
          n_reads++;
        end
        q.push_back(t);
      end
      prev_stall = (obi_req_o === 1'b1) && !obi_gnt_i && rst_ni;
      prev_addr  = obi_addr_o;
      prev_we    = obi_we_o;
      prev_wdata = obi_wdata_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic chk, input logic [AW-1:0] base, input logic [31:0] pat);
    cur_base = base; cur_pat = pat;
    exp_widx = 0; exp_ridx = 0; n_writes = 0; n_reads = 0;
    seq_err = 0; proto_err = 0;
    check_i = chk; base_addr_i = base; pattern_i = pat;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 1;
    while (!done_o && cycles < budget) begin
      tick();
      cycles++;
    end
    check_eq({tag, "_done"}, done_o, 1'b1);
  endtask

  initial begin
    int cyc_n, got, bad, late;
    for (int i = 0; i < NW; i++) begin
      mem[i] = '0;
      corrupt[i] = '0;
    end

    // Reset
    repeat (3) tick();
    check_eq("rst_req", obi_req_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_err_count", err_count_o, 16'h0);
    check_eq("rst_addr", obi_addr_o, '0);
    check_eq("rst_be", obi_be_o, '0);
    rst_ni = 1'b1;
    tick();

    // 1: fill only
    do_start(1'b0, 48'h1000, 32'h0);
    wait_done("t1", 100, cyc_n);
    check_eq("t1_cycles", cyc_n, 10);
    check_eq("t1_busy", busy_o, 1'b0);
    check_eq("t1_error", error_o, 1'b0);
    check_eq("t1_writes", n_writes, 8);
    check_eq("t1_reads", n_reads, 0);
    check_eq("t1_word3", mem[3], {16{32'h0000_0003}});
    check_eq("t1_word7", mem[7], {16{32'h0000_0007}});
    check_eq("t1_seq", seq_err, 0);
    check_eq("t1_proto", proto_err, 0);

    // 2: fill + check, ideal memory
    do_start(1'b1, 48'h1000, 32'hA5A5_A5A5);
    wait_done("t2", 100, cyc_n);
    check_eq("t2_writes", n_writes, 8);
    check_eq("t2_reads", n_reads, 8);
    check_eq("t2_word7", mem[7], {16{32'hA5A5_A5A2}});
    check_eq("t2_error", error_o, 1'b0);
    check_eq("t2_err_count", err_count_o, 16'h0);
    check_eq("t2_seq", seq_err, 0);

    // 3: words 3 and 5 corrupted on read
    corrupt[3] = {{(DW-1){1'b0}}, 1'b1};
    corrupt[5] = {1'b1, {(DW-1){1'b0}}};
    do_start(1'b1, 48'h1000, 32'h1234_5678);
    wait_done("t3", 100, cyc_n);
    check_eq("t3_error", error_o, 1'b1);
    check_eq("t3_err_addr", err_addr_o, 48'h10C0);
    check_eq("t3_err_count", err_count_o, 16'd2);
    corrupt[3] = '0;
    corrupt[5] = '0;

    // 4: random grant stalls, random response delay
    stall_en = 1; dly_mode = 1;
    do_start(1'b1, 48'h2000, 32'hDEAD_BEEF);
    wait_done("t4", 600, cyc_n);
    check_eq("t4_error", error_o, 1'b0);
    check_eq("t4_writes", n_writes, 8);
    check_eq("t4_reads", n_reads, 8);
    check_eq("t4_seq", seq_err, 0);
    check_eq("t4_proto", proto_err, 0);
    stall_en = 0;

    // 5: reset during READ with responses in flight
    dly_mode = 2;
    for (int i = 0; i < NW; i++) corrupt[i] = {DW{1'b1}};
    do_start(1'b1, 48'h1000, 32'h0);
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      tick();
      if (busy_o && !obi_we_o && q.size() == 2) got = 1;
    end
    check_eq("t5_reach_read", got, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_eq("t5_req", obi_req_o, 1'b0);
    check_eq("t5_busy", busy_o, 1'b0);
    check_eq("t5_error", error_o, 1'b0);
    check_eq("t5_err_count", err_count_o, 16'h0);
    check_eq("t5_err_addr", err_addr_o, '0);
    check_eq("t5_wdata_be", {obi_we_o, obi_be_o, obi_addr_o}, '0);
    late = (q.size() > 0) ? 1 : 0;
    check_eq("t5_late_pending", late, 1);
    bad = 0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      tick();
      if (error_o || busy_o || done_o || obi_req_o || err_count_o != 16'h0) bad++;
    end
    check_eq("t5_late_ignored", bad, 0);
    for (int i = 0; i < NW; i++) corrupt[i] = '0;
    dly_mode = 0;
    do_start(1'b1, 48'h1000, 32'h5555_0000);
    wait_done("t5_rerun", 100, cyc_n);
    check_eq("t5_rerun_error", error_o, 1'b0);
    check_eq("t5_rerun_reads", n_reads, 8);

    // 6: start ignored while busy, honoured in DONE with cleared error state
    corrupt[3] = {DW{1'b1}};
    do_start(1'b1, 48'h1000, 32'h0F0F_0F0F);
    repeat (3) tick();
    base_addr_i = 48'h9000;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done("t6a", 100, cyc_n);
    check_eq("t6a_writes", n_writes, 8);
    check_eq("t6a_seq", seq_err, 0);
    check_eq("t6a_err_addr", err_addr_o, 48'h10C0);
    check_eq("t6a_err_count", err_count_o, 16'd1);
    corrupt[3] = '0;
    corrupt[5] = {DW{1'b1}};
    do_start(1'b1, 48'h1000, 32'h0F0F_0F0F);
    check_eq("t6b_cleared", {error_o, err_count_o}, 17'h0);
    check_eq("t6b_busy", busy_o, 1'b1);
    wait_done("t6b", 100, cyc_n);
    check_eq("t6b_err_addr", err_addr_o, 48'h1140);
    check_eq("t6b_err_count", err_count_o, 16'd1);
    corrupt[5] = '0;
    do_start(1'b1, 48'h1000, 32'h0F0F_0F0F);
    check_eq("t6c_cleared", {error_o, err_addr_o}, '0);
    wait_done("t6c", 100, cyc_n);
    check_eq("t6c_error", error_o, 1'b0);
    check_eq("t6c_reads", n_reads, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
